// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, write mask and the memory arbiter FSM state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

endpackage

// File: rtl/mem_req_latch.sv
// Load-enabled holding register for the granted request (address, wdata, mask, op).
module mem_req_latch
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  lc3b_word      ld_address,
    input  lc3b_word      ld_wdata,
    input  lc3b_mem_wmask ld_byte_enable,
    input  logic          ld_write,
    output lc3b_word      address,
    output lc3b_word      wdata,
    output lc3b_mem_wmask byte_enable,
    output logic          write_op
);

    lc3b_word      address_q, address_d;
    lc3b_word      wdata_q, wdata_d;
    lc3b_mem_wmask byte_enable_q, byte_enable_d;
    logic          write_op_q, write_op_d;

    always_comb begin
        address_d     = address_q;
        wdata_d       = wdata_q;
        byte_enable_d = byte_enable_q;
        write_op_d    = write_op_q;
        if (load) begin
            address_d     = ld_address;
            wdata_d       = ld_wdata;
            byte_enable_d = ld_byte_enable;
            write_op_d    = ld_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_q     <= '0;
            wdata_q       <= '0;
            byte_enable_q <= '0;
            write_op_q    <= 1'b0;
        end else begin
            address_q     <= address_d;
            wdata_q       <= wdata_d;
            byte_enable_q <= byte_enable_d;
            write_op_q    <= write_op_d;
        end
    end

    assign address     = address_q;
    assign wdata       = wdata_q;
    assign byte_enable = byte_enable_q;
    assign write_op    = write_op_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one physical memory, one transaction in flight.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT contested data grants.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_read,
    input  lc3b_word      if_address,
    output lc3b_word      if_rdata,
    output logic          if_resp,
    input  logic          dm_read,
    input  logic          dm_write,
    input  lc3b_word      dm_address,
    input  lc3b_word      dm_wdata,
    input  lc3b_mem_wmask dm_byte_enable,
    output lc3b_word      dm_rdata,
    output logic          dm_resp,
    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_word      mem_wdata,
    output lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_rdata,
    input  logic          mem_resp,
    output lc3b_arb_state state_dbg
);

    lc3b_arb_state state_q, state_d;
    logic          d_pend, give_i;
    logic          load;
    lc3b_word      ld_address, ld_wdata;
    lc3b_mem_wmask ld_byte_enable;
    logic          ld_write;
    lc3b_mem_wmask lat_byte_enable;
    logic          lat_write;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_q, starve_d;
`endif

    assign d_pend = dm_read | dm_write;

`ifdef ARB_STARVE_GUARD_EN
    assign give_i = if_read && (!d_pend || (starve_q == LIMIT_CNT));
`else
    assign give_i = if_read && !d_pend;
`endif

    always_comb begin
        state_d        = state_q;
        load           = 1'b0;
        ld_address     = '0;
        ld_wdata       = '0;
        ld_byte_enable = '0;
        ld_write       = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        starve_d       = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (give_i) begin
                    state_d        = SERVE_I;
                    load           = 1'b1;
                    ld_address     = if_address;
                    ld_byte_enable = 2'b11;
`ifdef ARB_STARVE_GUARD_EN
                    starve_d       = '0;
`endif
                end else if (d_pend) begin
                    state_d        = SERVE_D;
                    load           = 1'b1;
                    ld_address     = dm_address;
                    ld_wdata       = dm_wdata;
                    // Read+write together is a write; reads always use the full mask.
                    ld_write       = dm_write;
                    ld_byte_enable = dm_write ? dm_byte_enable : 2'b11;
`ifdef ARB_STARVE_GUARD_EN
                    if (if_read && (starve_q != LIMIT_CNT))
                        starve_d = starve_q + 1'b1;
`endif
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

`ifdef ARB_STARVE_GUARD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`endif

    mem_req_latch u_req_latch (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .ld_address     (ld_address),
        .ld_wdata       (ld_wdata),
        .ld_byte_enable (ld_byte_enable),
        .ld_write       (ld_write),
        .address        (mem_address),
        .wdata          (mem_wdata),
        .byte_enable    (lat_byte_enable),
        .write_op       (lat_write)
    );

    // Strobes depend only on registered state, so reset drops them immediately.
    assign mem_read        = (state_q == SERVE_I) || ((state_q == SERVE_D) && !lat_write);
    assign mem_write       = (state_q == SERVE_D) && lat_write;
    assign mem_byte_enable = (state_q == IDLE) ? 2'b00 : lat_byte_enable;

    assign if_resp   = mem_resp && (state_q == SERVE_I);
    assign dm_resp   = mem_resp && (state_q == SERVE_D);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign state_dbg = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive data-port wins allowed while fetch waits; used only when ARB_STARVE_GUARD_EN is defined.
REQ-002 Single clock; reset asynchronous, active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  async active-high reset.
REQ-005 if_read  in  1  fetch-stage read request, held until if_resp.
REQ-006 if_address  in  16 (lc3b_word)  fetch address.
REQ-007 if_rdata  out  16 (lc3b_word)  fetch read data, valid when if_resp=1.
REQ-008 if_resp  out  1  fetch transaction done, one-cycle pulse.
REQ-009 dm_read / dm_write  in  1 each  memory-stage read/write requests, held until dm_resp.
REQ-010 dm_address, dm_wdata  in  16 each (lc3b_word)  data address, write data.
REQ-011 dm_byte_enable  in  2 (lc3b_mem_wmask)  write byte mask.
REQ-012 dm_rdata  out  16 (lc3b_word); dm_resp  out  1  data read data and done pulse.
REQ-013 mem_read, mem_write  out  1 each; mem_address, mem_wdata  out  16 each; mem_byte_enable  out  2  physical memory request.
REQ-014 mem_rdata  in  16; mem_resp  in  1  physical memory response.

Function
REQ-015 FSM states: IDLE, SERVE_I, SERVE_D; exactly one memory transaction outstanding at any time.
REQ-016 IDLE: on a clock edge with only if_read pending -> SERVE_I; with only dm_read|dm_write pending -> SERVE_D; none -> stay IDLE.
REQ-017 IDLE with both pending, macro off: -> SERVE_D (data port fixed priority).
REQ-018 On each grant, address, wdata, byte_enable and op are latched; mem_* are driven from the latch only, never combinationally from requester inputs.
REQ-019 SERVE_I: mem_read=1, mem_write=0, mem_address=latched if_address.
REQ-020 SERVE_D: mem_write=1 if latched op is write, otherwise mem_read=1; mem_byte_enable=latched mask for writes, 2'b11 for reads.
REQ-021 dm_read and dm_write both asserted: treated as a write, with mem_read=0.
REQ-022 if_resp = mem_resp AND state==SERVE_I; dm_resp = mem_resp AND state==SERVE_D; both combinational and never high together.
REQ-023 if_rdata = dm_rdata = mem_rdata, passed through combinationally.
REQ-024 On the edge where mem_resp=1, the FSM returns to IDLE; the next grant happens one edge later (one-cycle IDLE bubble).
REQ-025 Minimum latency: request at cycle N gives mem_* asserted at N+1 and resp in the same cycle as mem_resp.
REQ-026 Requester deasserting before resp: the transaction still runs until mem_resp, and the resp pulse is still issued.
REQ-027 In IDLE, all mem_read, mem_write, if_resp and dm_resp are 0.

Reset
REQ-028 reset asserted: state=IDLE immediately (asynchronous).
REQ-029 Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, if_resp=0, dm_resp=0, starve counter=0.
REQ-030 Reset mid-transaction abandons it; no resp is issued for it after reset release.

Configuration
REQ-031 Macro ARB_STARVE_GUARD_EN.
REQ-032 Defined: a counter increments on each SERVE_D grant made while if_read is pending.
REQ-033 Defined: when the counter equals STARVE_LIMIT, the next contested grant goes to SERVE_I and the counter clears; any SERVE_I grant clears it; the counter saturates and never wraps.
REQ-034 Undefined: no counter is present; strict data priority per REQ-017.

Structure
REQ-035 lc3b_types package gains the lc3b_arb_state enum (IDLE, SERVE_I, SERVE_D); lc3b_word and lc3b_mem_wmask are reused.
REQ-036 One sub-module, mem_req_latch: load-enabled register holding address, wdata, byte_enable and op; async-reset to 0.

Verification
REQ-037 if_read=1, if_address=16'h0040; memory responds after 3 cycles with 16'h1234 -> mem_read high from N+1 for 3 cycles, if_resp pulse, if_rdata=16'h1234.
REQ-038 dm_write=1, dm_address=16'h2000, dm_wdata=16'hBEEF, dm_byte_enable=2'b01 -> mem_write=1, mem_byte_enable=2'b01, mem_wdata=16'hBEEF, dm_resp pulse.
REQ-039 if_read and dm_read held continuously, macro off -> grant order D,D,D..., fetch starves; macro on with STARVE_LIMIT=4 -> D,D,D,D,I repeating.
REQ-040 Assert reset while in SERVE_D with mem_resp pending -> mem_read/mem_write drop in the same cycle; no dm_resp after release.
REQ-041 Change dm_address after grant -> mem_address still equals the latched value until mem_resp.
REQ-042 dm_read and dm_write both asserted -> mem_write=1, mem_read=0.
